// File: rtl/imc_pkg.sv
// Shared types and default sizing for the bit-serial in-memory MAC array.
package imc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_ROWS  = 16;
   localparam int unsigned DEF_BANKS = 4;
   localparam int unsigned DEF_XBITS = 4;
   localparam int unsigned DEF_WBITS = 4;

   // Width that holds a sum of n unsigned wbits-wide terms without truncation.
   function automatic int unsigned psum_width(input int unsigned n, input int unsigned wbits);
      return wbits + $clog2(n);
   endfunction

endpackage

// File: rtl/imc_adder_tree_p.sv
// Combinational partial-sum: adds every weight whose activation bit is set.
module imc_adder_tree_p
   import imc_pkg::*;
#(
   parameter  int unsigned N      = DEF_ROWS * DEF_BANKS,
   parameter  int unsigned WBITS  = DEF_WBITS,
   localparam int unsigned PSUM_W = psum_width(N, WBITS)
) (
   input  logic [N-1:0]            sel,
   input  logic [N-1:0][WBITS-1:0] w,
   output logic [PSUM_W-1:0]       psum
);

   // Gated accumulation of all N weights; the output width covers N * max weight.
   always_comb begin
      psum = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (sel[i]) begin
            psum = psum + PSUM_W'(w[i]);
         end
      end
   end

endmodule

// File: rtl/bitserial_mac_array.sv
// Bit-serial MAC: one activation bit per cycle, MSB first, over BANKS x ROWS weights.
module bitserial_mac_array
   import imc_pkg::*;
#(
   parameter  int unsigned ROWS   = DEF_ROWS,
   parameter  int unsigned BANKS  = DEF_BANKS,
   parameter  int unsigned XBITS  = DEF_XBITS,
   parameter  int unsigned WBITS  = DEF_WBITS,
   localparam int unsigned PSUM_W = psum_width(ROWS * BANKS, WBITS),
   localparam int unsigned RES_W  = PSUM_W + XBITS + 1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    abort,
   input  logic                                    signed_mode,
   input  logic [ROWS-1:0][XBITS-1:0]              xin,
   input  logic [BANKS-1:0][ROWS-1:0][WBITS-1:0]   wbank,
   output logic                                    busy,
   output logic                                    done,
   output logic signed [RES_W-1:0]                 result
);

   localparam int unsigned N     = ROWS * BANKS;
   localparam int unsigned IDX_W = (XBITS > 1) ? $clog2(XBITS) : 1;

   state_t state, state_nxt;
   logic   busy_nxt, done_nxt;

   logic [ROWS-1:0][XBITS-1:0]            x_lat;
   logic [BANKS-1:0][ROWS-1:0][WBITS-1:0] w_lat;
   logic                                  sm_lat;
   logic signed [RES_W-1:0]               acc;
   logic signed [RES_W-1:0]               acc_nxt;
   logic signed [RES_W-1:0]               psum_ext;
   logic [IDX_W-1:0]                      bit_idx;

   logic [ROWS-1:0]            xbit;
   logic [N-1:0]               tree_sel;
   logic [N-1:0][WBITS-1:0]    tree_w;
   logic [PSUM_W-1:0]          psum;

   logic start_ok;
   logic run_step;
   logic last_bit;
   logic msb_bit;

   assign start_ok = (state == IDLE) && start;
   assign run_step = (state == RUN) && !abort;
   assign last_bit = (bit_idx == '0);
   assign msb_bit  = (bit_idx == IDX_W'(XBITS - 1));

   // Current activation bit of every row, taken from the latched operands.
   for (genvar r = 0; r < int'(ROWS); r++) begin : g_xbit
      assign xbit[r] = x_lat[r][bit_idx];
   end

   // Flatten bank/row into one adder-tree lane; each bank reuses the row's activation bit.
   for (genvar b = 0; b < int'(BANKS); b++) begin : g_bank
      for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
         assign tree_sel[b*ROWS + r] = xbit[r];
         assign tree_w[b*ROWS + r]   = w_lat[b][r];
      end
   end

   imc_adder_tree_p #(
      .N     (N),
      .WBITS (WBITS)
   ) u_tree (
      .sel  (tree_sel),
      .w    (tree_w),
      .psum (psum)
   );

   // Shift-and-add step; the signed MSB carries negative weight, so it seeds acc with -psum.
   always_comb begin
      psum_ext = RES_W'(psum);
      if (sm_lat && msb_bit) begin
         acc_nxt = RES_W'(0) - psum_ext;
      end else begin
         acc_nxt = (acc <<< 1) + psum_ext;
      end
   end

   // Next-state and registered-output decode; abort outranks bit progression.
   always_comb begin
      state_nxt = state;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
   end

   // State and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   // Operand latch, accumulator, bit index and result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         x_lat   <= '0;
         w_lat   <= '0;
         sm_lat  <= 1'b0;
         acc     <= '0;
         bit_idx <= '0;
         result  <= '0;
      end else if (start_ok) begin
         x_lat   <= xin;
         w_lat   <= wbank;
         sm_lat  <= signed_mode;
         acc     <= '0;
         bit_idx <= IDX_W'(XBITS - 1);
      end else if (run_step) begin
         acc <= acc_nxt;
         if (last_bit) begin
            result <= acc_nxt;
         end else begin
            bit_idx <= bit_idx - IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bitserial_mac_array.sv
// Directed plus randomized bench for bitserial_mac_array with an arithmetic reference model.
module tb_bitserial_mac_array;

   localparam int unsigned ROWS  = 16;
   localparam int unsigned BANKS = 4;
   localparam int unsigned XBITS = 4;
   localparam int unsigned WBITS = 4;
   localparam int unsigned RES_W = 15;

   localparam int unsigned ROWS2  = 8;
   localparam int unsigned BANKS2 = 2;
   localparam int unsigned XBITS2 = 8;
   localparam int unsigned WBITS2 = 2;
   localparam int unsigned RES_W2 = 15;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic abort;
   logic smode;
   logic [ROWS-1:0][XBITS-1:0]            xin;
   logic [BANKS-1:0][ROWS-1:0][WBITS-1:0] wbank;
   logic                                  busy;
   logic                                  done;
   logic signed [RES_W-1:0]               result;

   logic start2;
   logic abort2;
   logic smode2;
   logic [ROWS2-1:0][XBITS2-1:0]             xin2;
   logic [BANKS2-1:0][ROWS2-1:0][WBITS2-1:0] wbank2;
   logic                                     busy2;
   logic                                     done2;
   logic signed [RES_W2-1:0]                 result2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bitserial_mac_array #(
      .ROWS(ROWS), .BANKS(BANKS), .XBITS(XBITS), .WBITS(WBITS)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .signed_mode(smode),
      .xin(xin), .wbank(wbank), .busy(busy), .done(done), .result(result)
   );

   bitserial_mac_array #(
      .ROWS(ROWS2), .BANKS(BANKS2), .XBITS(XBITS2), .WBITS(WBITS2)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2), .signed_mode(smode2),
      .xin(xin2), .wbank(wbank2), .busy(busy2), .done(done2), .result(result2)
   );

   // Dot product of activation values with per-row weight totals.
   function automatic longint model(input logic [ROWS-1:0][XBITS-1:0] x,
                                    input logic [BANKS-1:0][ROWS-1:0][WBITS-1:0] w,
                                    input bit s);
      longint total = 0;
      longint xv;
      longint ws;
      for (int r = 0; r < int'(ROWS); r++) begin
         xv = longint'(x[r]);
         if (s && x[r][XBITS-1]) xv = xv - (longint'(1) << XBITS);
         ws = 0;
         for (int b = 0; b < int'(BANKS); b++) ws = ws + longint'(w[b][r]);
         total = total + xv * ws;
      end
      return total;
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int xv, input int wv);
      for (int r = 0; r < int'(ROWS); r++) begin
         xin[r] = XBITS'(xv);
         for (int b = 0; b < int'(BANKS); b++) wbank[b][r] = WBITS'(wv);
      end
   endtask

   task automatic randomize_ops();
      for (int r = 0; r < int'(ROWS); r++) begin
         xin[r] = XBITS'($urandom);
         for (int b = 0; b < int'(BANKS); b++) wbank[b][r] = WBITS'($urandom);
      end
   endtask

   task automatic count_done(input string tag, input int cycles);
      int nd = 0;
      for (int i = 0; i < cycles; i++) begin
         if (done === 1'b1) nd++;
         tick();
      end
      check(tag, nd, 0);
   endtask

   // One operation: latency, busy width, result, then no stray done afterwards.
   task automatic run_op(input string tag, input longint exp, input bit disturb);
      int cyc  = 0;
      int bcnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) bcnt++;
         if (disturb && cyc == 1) begin
            start = 1'b1;
            smode = ~smode;
            randomize_ops();
         end
         if (disturb && cyc == 2) start = 1'b0;
         tick();
         cyc++;
      end
      check({tag, "_latency"}, cyc, XBITS);
      check({tag, "_busy_cycles"}, bcnt, XBITS);
      check({tag, "_result"}, result, exp);
      check({tag, "_busy_at_done"}, busy, 0);
      tick();
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_result_hold"}, result, exp);
      count_done({tag, "_no_extra_done"}, 8);
   endtask

   initial begin
      longint exp;
      longint prior;
      int     cyc;

      rst = 1'b1; start = 1'b0; abort = 1'b0; smode = 1'b0;
      xin = '0; wbank = '0;
      start2 = 1'b0; abort2 = 1'b0; smode2 = 1'b0;
      xin2 = '0; wbank2 = '0;
      tick();
      tick();
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_result", result, 0);
      check("reset_result2", result2, 0);
      rst = 1'b0;
      tick();

      // Full-scale unsigned.
      fill(15, 15);
      smode = 1'b0;
      run_op("all15_unsigned", 14400, 1'b0);

      // Single nonzero product, unsigned then signed.
      fill(0, 0);
      xin[0] = 4'b1010;
      wbank[0][0] = 4'd3;
      smode = 1'b0;
      run_op("single_unsigned", 30, 1'b0);
      smode = 1'b1;
      run_op("single_signed", -18, 1'b0);

      // All activations -1 in signed mode.
      fill(15, 15);
      smode = 1'b1;
      run_op("all_neg1_signed", -960, 1'b0);

      // Inputs and start disturbed mid-operation must not matter.
      randomize_ops();
      smode = 1'b0;
      exp = model(xin, wbank, 1'b0);
      run_op("disturb", exp, 1'b1);
      prior = exp;

      // Abort during the second RUN cycle.
      fill(15, 15);
      smode = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("abort_busy_run1", busy, 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result_kept", result, prior);
      count_done("abort_no_done", 8);
      run_op("after_abort", 14400, 1'b0);

      // Abort while idle is inert.
      abort = 1'b1;
      tick();
      tick();
      check("idle_abort_busy", busy, 0);
      check("idle_abort_done", done, 0);
      check("idle_abort_result", result, 14400);
      abort = 1'b0;

      // Randomized operations against the model.
      for (int k = 0; k < 16; k++) begin
         randomize_ops();
         smode = 1'($urandom);
         exp = model(xin, wbank, smode);
         run_op($sformatf("rand%0d", k), exp, 1'b0);
      end

      // Reset in the middle of RUN.
      fill(15, 15);
      smode = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 0);
      rst = 1'b0;
      count_done("midrst_no_done", 8);

      // Alternate geometry, all-ones unsigned.
      xin2 = '1;
      wbank2 = '1;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 0;
      while (done2 !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("alt_latency", cyc, XBITS2);
      check("alt_result", result2, 12240);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
